vga_fb_arbiter: RTL



---
 rtl/vga_fb_pkg.sv | 45 ++++
 rtl/vga_fetch_sched.sv | 52 +++++
 rtl/vga_fb_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: shared geometry constants, sized compare constants and the
// clear-engine state enum for the framebuffer arbiter.
package vga_fb_pkg;

  localparam int H_PIXELS = 800;    // pixel clocks per line
  localparam int H_START  = 160;    // h count of active pixel x=0
  localparam int V_START  = 35;     // v count of active line y=0
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int WPL      = 40;     // 16-pixel words per line
  localparam int FB_WORDS = 19200;
  localparam int ADDR_W   = 15;
  localparam int CNT_W    = 10;     // width of the vga_ctrl counters

  // The bus is registered, so slot/load decode looks one cycle ahead:
  // a display read on the bus at H_START+16g-2 is decided while the
  // counter reads H_START+16g-3.
  localparam logic [CNT_W-1:0] SLOT_H_LO = CNT_W'(H_START - 3);
  localparam logic [CNT_W-1:0] SLOT_H_HI = CNT_W'(H_START + H_ACTIVE - 19);
  localparam logic [CNT_W-1:0] LOAD_H_LO = CNT_W'(H_START - 1);
  localparam logic [CNT_W-1:0] LOAD_H_HI = CNT_W'(H_START + H_ACTIVE - 17);
  localparam logic [CNT_W-1:0] V_LO      = CNT_W'(V_START);
  localparam logic [CNT_W-1:0] V_HI      = CNT_W'(V_START + V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_PIXELS - 1);

  localparam logic [3:0] SLOT_PH = SLOT_H_LO[3:0];
  localparam logic [3:0] LOAD_PH = LOAD_H_LO[3:0];

  localparam logic [ADDR_W-1:0] WPL_A      = ADDR_W'(WPL);
  localparam logic [ADDR_W-1:0] FB_WORDS_A = ADDR_W'(FB_WORDS);

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } fb_state_e;

  // Registered RAM strobe bundle.
  typedef struct packed {
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       wdata;
  } bus_req_t;

endpackage

// File: rtl/vga_fetch_sched.sv
// vga_fetch_sched: display-slot decode, incremental line base and shifter
// load strobe.
//   clk, rst_n        pixel clock, async active-low reset
//   h_pixel_cnt_i     horizontal count from vga_ctrl
//   v_line_cnt_i      vertical count from vga_ctrl
//   slot_next_o       next bus cycle is a display read
//   slot_addr_o       word address for that read (line_base + g)
//   load_o            load the pixel shifter with mem_rdata at this edge
module vga_fetch_sched
  import vga_fb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CNT_W-1:0]  h_pixel_cnt_i,
  input  logic [CNT_W-1:0]  v_line_cnt_i,
  output logic              slot_next_o,
  output logic [ADDR_W-1:0] slot_addr_o,
  output logic              load_o
);

  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic              act_line;
  logic [5:0]        slot_g;

  assign act_line = (v_line_cnt_i >= V_LO) && (v_line_cnt_i <= V_HI);

  // Slots and loads are 16 apart, so a 4-bit phase match plus a range
  // compare replaces any per-group counter.
  assign slot_next_o = act_line && (h_pixel_cnt_i[3:0] == SLOT_PH) &&
                       (h_pixel_cnt_i >= SLOT_H_LO) && (h_pixel_cnt_i <= SLOT_H_HI);
  assign load_o      = act_line && (h_pixel_cnt_i[3:0] == LOAD_PH) &&
                       (h_pixel_cnt_i >= LOAD_H_LO) && (h_pixel_cnt_i <= LOAD_H_HI);

  assign slot_g      = 6'((h_pixel_cnt_i - SLOT_H_LO) >> 4);
  assign slot_addr_o = line_base_q + ADDR_W'(slot_g);

  // line_base tracks (v-V_START)*WPL by stepping at the end of each
  // active line; all fetches of a line finish well before H_LAST.
  always_comb begin
    line_base_d = line_base_q;
    if (act_line && (h_pixel_cnt_i == H_LAST)) begin
      if (v_line_cnt_i == V_HI) line_base_d = '0;
      else                      line_base_d = line_base_q + WPL_A;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) line_base_q <= '0;
    else        line_base_q <= line_base_d;
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: single-port framebuffer scheduler. Display fetches take
// fixed slots, the clear engine and the host share the remaining cycles
// (clear first), and the fetched words are serialised onto pix_out.
//   clk_pixel, rst_n            pixel clock, async active-low reset
//   h_pixel_cnt, v_line_cnt     vga_ctrl counters
//   mem_en/we/addr/wdata        registered RAM strobes (hold when idle)
//   mem_rdata                   RAM data, valid the cycle after access
//   host_req/we/addr/wdata      host request, stable until host_ack
//   host_ack                    grant pulse, coincides with bus cycle
//   host_rdata, host_rvalid     read data, two cycles after the grant
//   clr_start, clr_value        clear request and fill word
//   clr_busy, clr_done          clear in progress / completion pulse
//   pix_out                     serial pixel, MSB of each word first
module vga_fb_arbiter
  import vga_fb_pkg::*;
(
  input  logic              clk_pixel,
  input  logic              rst_n,
  input  logic [CNT_W-1:0]  h_pixel_cnt,
  input  logic [CNT_W-1:0]  v_line_cnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [15:0]       host_wdata,
  output logic              host_ack,
  output logic [15:0]       host_rdata,
  output logic              host_rvalid,
  input  logic              clr_start,
  input  logic [15:0]       clr_value,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              pix_out
);

  fb_state_e         state_q, state_d;
  bus_req_t          bus_q, bus_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [15:0]       clr_val_q, clr_val_d;
  logic              host_ack_q, host_ack_d;
  logic              clr_done_q, clr_done_d;
  logic [1:0]        rd_vld_q, rd_vld_d;   // host read in flight: bus cycle, data cycle
  logic [1:0]        rd_oor_q, rd_oor_d;   // matching out-of-range flags
  logic [15:0]       host_rdata_q, host_rdata_d;
  logic              host_rvalid_q, host_rvalid_d;
  logic [15:0]       shift_q, shift_d;
  logic              pix_q, pix_d;

  logic              slot_next;
  logic [ADDR_W-1:0] slot_addr;
  logic              load;
  logic              host_oor;
  logic              rd_issue;

  vga_fetch_sched u_sched (
    .clk           (clk_pixel),
    .rst_n         (rst_n),
    .h_pixel_cnt_i (h_pixel_cnt),
    .v_line_cnt_i  (v_line_cnt),
    .slot_next_o   (slot_next),
    .slot_addr_o   (slot_addr),
    .load_o        (load)
  );

  assign host_oor = (host_addr >= FB_WORDS_A);

  // Arbitration and clear FSM. A request is still presented during its
  // own ack cycle, so a grant is never given while host_ack_q is high;
  // otherwise the same access would be granted twice.
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    clr_val_d  = clr_val_q;
    bus_d      = bus_q;
    bus_d.en   = 1'b0;
    host_ack_d = 1'b0;
    clr_done_d = 1'b0;
    rd_issue   = 1'b0;

    if (slot_next) begin
      bus_d.en   = 1'b1;
      bus_d.we   = 1'b0;
      bus_d.addr = slot_addr;
    end

    unique case (state_q)
      RUN: begin
        if (clr_start) begin
          // No host grant on this edge: it would land in the first
          // clr_busy cycle.
          state_d   = CLEAR;
          clr_cnt_d = '0;
          clr_val_d = clr_value;
        end else if (host_req && !host_ack_q && !slot_next) begin
          host_ack_d = 1'b1;
          rd_issue   = !host_we;
          if (!host_oor) begin
            bus_d.en    = 1'b1;
            bus_d.we    = host_we;
            bus_d.addr  = host_addr;
            bus_d.wdata = host_wdata;
          end
        end
      end
      CLEAR: begin
        if (clr_cnt_q == FB_WORDS_A) begin
          state_d    = RUN;
          clr_done_d = 1'b1;
        end else if (!slot_next) begin
          bus_d.en    = 1'b1;
          bus_d.we    = 1'b1;
          bus_d.addr  = clr_cnt_q;
          bus_d.wdata = clr_val_q;
          clr_cnt_d   = clr_cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Host read return path and pixel shifter.
  always_comb begin
    rd_vld_d      = {rd_vld_q[0], rd_issue};
    rd_oor_d      = {rd_oor_q[0], host_oor};
    host_rvalid_d = rd_vld_q[1];
    host_rdata_d  = host_rdata_q;
    if (rd_vld_q[1]) host_rdata_d = rd_oor_q[1] ? 16'h0000 : mem_rdata;

    shift_d = load ? mem_rdata : {shift_q[14:0], 1'b0};
    pix_d   = shift_q[15];
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      bus_q         <= '0;
      clr_cnt_q     <= '0;
      clr_val_q     <= '0;
      host_ack_q    <= 1'b0;
      clr_done_q    <= 1'b0;
      rd_vld_q      <= '0;
      rd_oor_q      <= '0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
      shift_q       <= '0;
      pix_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      bus_q         <= bus_d;
      clr_cnt_q     <= clr_cnt_d;
      clr_val_q     <= clr_val_d;
      host_ack_q    <= host_ack_d;
      clr_done_q    <= clr_done_d;
      rd_vld_q      <= rd_vld_d;
      rd_oor_q      <= rd_oor_d;
      host_rdata_q  <= host_rdata_d;
      host_rvalid_q <= host_rvalid_d;
      shift_q       <= shift_d;
      pix_q         <= pix_d;
    end
  end

  assign mem_en      = bus_q.en;
  assign mem_we      = bus_q.we;
  assign mem_addr    = bus_q.addr;
  assign mem_wdata   = bus_q.wdata;
  assign host_ack    = host_ack_q;
  assign host_rdata  = host_rdata_q;
  assign host_rvalid = host_rvalid_q;
  assign clr_busy    = (state_q == CLEAR);
  assign clr_done    = clr_done_q;
  assign pix_out     = pix_q;

endmodule
